// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder built on one 4-bit adder, one nibble per clock.
// Optional subtract mode (port i_sub) is enabled by defining SERIAL_ADDER_SUB_EN.

module adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_c};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_carry,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [CW+1:0]    base;
  logic [3:0]       nib_s;
  logic             nib_c;

  assign base = {cnt_q, 2'b00};

  adder_4bit u_add (
    .i_a (op1_q[base +: 4]),
    .i_b (op2_q[base +: 4]),
    .i_c (carry_q),
    .o_s (nib_s),
    .o_c (nib_c)
  );

  // next-state, datapath update and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          op1_d   = i_op1;
`ifdef SERIAL_ADDER_SUB_EN
          op2_d   = i_sub ? ~i_op2 : i_op2;
          carry_d = i_sub ? 1'b1 : i_carry;
`else
          op2_d   = i_op2;
          carry_d = i_carry;
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: 4] = nib_s;
        carry_d = nib_c;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          cout_d  = nib_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign o_sum   = sum_q;
  assign o_carry = cout_q;

endmodule
